// File: rtl/uwire_cfg_pkg.sv
// Shared types and width helpers for the MICROWIRE configuration sequencer.
package uwire_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH,
        ST_GAP,
        ST_LOCK_WAIT
    } state_t;

    typedef struct packed {
        state_t state;
        logic   bit_done;
    } dbg_t;

    function automatic int dev_width(input int num_dev);
        return (num_dev > 1) ? $clog2(num_dev) : 1;
    endfunction

    function automatic int idx_width(input int num_words);
        return $clog2(num_words + 1);
    endfunction

    // Width of a counter that must be able to hold max_val itself.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/uwire_bit_shifter.sv
// DATA_W-bit MSB-first serialiser; each bit is CLK_DIV cycles with sclk low,
// then CLK_DIV cycles with sclk high. Advances only while i_valid is high.
module uwire_bit_shifter
    import uwire_cfg_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_sclk,
    output logic              o_sdata,
    output logic              o_bit_done,
    output logic              o_word_done
);
    localparam int DIV_W = cnt_width(CLK_DIV);
    localparam int BIT_W = cnt_width(DATA_W);

    logic [DATA_W-1:0] r_shreg;
    logic [DIV_W-1:0]  r_div;
    logic [BIT_W-1:0]  r_bit;
    logic              r_high;
    logic              r_active;

    logic w_tick;
    logic w_last_bit;

    assign w_tick      = r_active && i_valid && (r_div == DIV_W'(CLK_DIV - 1));
    assign w_last_bit  = (r_bit == BIT_W'(DATA_W - 1));
    assign o_bit_done  = w_tick && r_high;
    assign o_word_done = o_bit_done && w_last_bit;
    assign o_sclk      = r_high;
    assign o_sdata     = r_shreg[DATA_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg  <= '0;
            r_div    <= '0;
            r_bit    <= '0;
            r_high   <= 1'b0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_shreg  <= i_data;
            r_div    <= '0;
            r_bit    <= '0;
            r_high   <= 1'b0;
            r_active <= 1'b1;
        end else if (r_active && i_valid) begin
            if (w_tick) begin
                r_div <= '0;
                if (!r_high) begin
                    r_high <= 1'b1;
                end else if (w_last_bit) begin
                    // Park the line low so data never lingers into the latch phase.
                    r_high   <= 1'b0;
                    r_active <= 1'b0;
                    r_shreg  <= '0;
                end else begin
                    r_high  <= 1'b0;
                    r_bit   <= r_bit + BIT_W'(1);
                    r_shreg <= r_shreg << 1;
                end
            end else begin
                r_div <= r_div + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/uwire_cfg_engine.sv
// MICROWIRE configuration sequencer: shifts a word table to several devices
// with per-device latch enables, then waits for a stable lock indication.
module uwire_cfg_engine
    import uwire_cfg_pkg::*;
#(
    parameter int DATA_W       = 32,
    parameter int NUM_WORDS    = 26,
    parameter int NUM_DEV      = 1,
    parameter int CLK_DIV      = 4,
    parameter int LE_CYCLES    = 4,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 125000000,
    localparam int DEV_W       = dev_width(NUM_DEV),
    localparam int IDX_W       = idx_width(NUM_WORDS)
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [NUM_WORDS-1:0][DATA_W-1:0]  cfg_data,
    input  logic [NUM_WORDS-1:0][DEV_W-1:0]   cfg_dev,
    input  logic                              lock_in,
    output logic                              busy,
    output logic                              done,
    output logic                              error,
    output logic [IDX_W-1:0]                  word_idx,
    output logic                              uwire_clk,
    output logic                              uwire_data,
    output logic [NUM_DEV-1:0]                uwire_le,
    output dbg_t                              dbg
);
    localparam int CNT_W = cnt_width((LE_CYCLES > CLK_DIV) ? LE_CYCLES : CLK_DIV);
    localparam int STB_W = cnt_width(LOCK_STABLE);
    localparam int TMO_W = cnt_width(LOCK_TIMEOUT);

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [IDX_W-1:0]   r_idx, w_idx_nxt;
    logic [DEV_W-1:0]   r_dev, w_dev_nxt;
    logic [NUM_DEV-1:0] r_le, w_le_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic               r_error, w_error_nxt;
    logic [STB_W-1:0]   r_stab, w_stab_nxt;
    logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;
    logic               r_lock_meta, r_lock_sync;

    logic               w_load;
    logic [IDX_W-1:0]   w_load_idx;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [DATA_W-1:0]  w_load_data;
    logic [DEV_W-1:0]   w_load_dev;
    logic [NUM_DEV-1:0] w_le_onehot;
    logic               w_dev_ok;
    logic               w_sh_valid;
    logic               w_bit_done;
    logic               w_word_done;

    assign w_idx_inc  = r_idx + IDX_W'(1);
    assign w_load_idx = (r_state == ST_IDLE) ? '0 : w_idx_inc;
    assign w_sh_valid = (r_state == ST_SHIFT);

    always_comb begin
        w_load_data = '0;
        w_load_dev  = '0;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (w_load_idx == IDX_W'(i)) begin
                w_load_data = cfg_data[i];
                w_load_dev  = cfg_dev[i];
            end
        end
    end

    // A device code with no matching LE line yields an all-zero pulse and an error.
    always_comb begin
        w_le_onehot = '0;
        w_dev_ok    = 1'b0;
        for (int d = 0; d < NUM_DEV; d++) begin
            if (r_dev == DEV_W'(d)) begin
                w_le_onehot[d] = 1'b1;
                w_dev_ok       = 1'b1;
            end
        end
    end

    uwire_bit_shifter #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_load),
        .i_valid     (w_sh_valid),
        .i_data      (w_load_data),
        .o_sclk      (uwire_clk),
        .o_sdata     (uwire_data),
        .o_bit_done  (w_bit_done),
        .o_word_done (w_word_done)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_dev_nxt   = r_dev;
        w_le_nxt    = r_le;
        w_busy_nxt  = r_busy;
        w_done_nxt  = r_done;
        w_error_nxt = r_error;
        w_stab_nxt  = r_stab;
        w_tmo_nxt   = r_tmo;
        w_load      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_dev_nxt   = w_load_dev;
                    w_idx_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_done_nxt  = 1'b0;
                    w_error_nxt = 1'b0;
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (w_word_done) begin
                    w_le_nxt    = w_le_onehot;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_LATCH;
                    if (!w_dev_ok) begin
                        w_error_nxt = 1'b1;
                    end
                end
            end
            ST_LATCH: begin
                if (r_cnt == CNT_W'(LE_CYCLES - 1)) begin
                    w_le_nxt    = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (r_cnt == CNT_W'(CLK_DIV - 1)) begin
                    w_cnt_nxt = '0;
                    w_idx_nxt = w_idx_inc;
                    if (w_idx_inc < IDX_W'(NUM_WORDS)) begin
                        w_load      = 1'b1;
                        w_dev_nxt   = w_load_dev;
                        w_state_nxt = ST_SHIFT;
                    end else begin
                        w_stab_nxt  = '0;
                        w_tmo_nxt   = '0;
                        w_state_nxt = ST_LOCK_WAIT;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_LOCK_WAIT: begin
                w_stab_nxt = r_lock_sync ? (r_stab + STB_W'(1)) : '0;
                w_tmo_nxt  = r_tmo + TMO_W'(1);
                // Stability is tested first so a simultaneous finish reports done.
                if (w_stab_nxt == STB_W'(LOCK_STABLE)) begin
                    w_done_nxt  = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_stab_nxt  = '0;
                    w_tmo_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo_nxt == TMO_W'(LOCK_TIMEOUT)) begin
                    w_error_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_stab_nxt  = '0;
                    w_tmo_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_dev       <= '0;
            r_le        <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_stab      <= '0;
            r_tmo       <= '0;
            r_lock_meta <= 1'b0;
            r_lock_sync <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_dev       <= w_dev_nxt;
            r_le        <= w_le_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_error     <= w_error_nxt;
            r_stab      <= w_stab_nxt;
            r_tmo       <= w_tmo_nxt;
            r_lock_meta <= lock_in;
            r_lock_sync <= r_lock_meta;
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign error        = r_error;
    assign word_idx     = r_idx;
    assign uwire_le     = r_le;
    assign dbg.state    = r_state;
    assign dbg.bit_done = w_bit_done;

endmodule

// File: tb/tb_uwire_cfg_engine.sv
// Directed bench for uwire_cfg_engine: table-driven full runs plus timeout,
// lock glitch, ignored restart and mid-run reset sequences.
module tb_uwire_cfg_engine;
    import uwire_cfg_pkg::*;

    localparam int DATA_W       = 32;
    localparam int NUM_WORDS    = 3;
    localparam int NUM_DEV      = 3;
    localparam int CLK_DIV      = 2;
    localparam int LE_CYCLES    = 4;
    localparam int LOCK_STABLE  = 16;
    localparam int LOCK_TIMEOUT = 1000;
    localparam int DEV_W        = 2;
    localparam int IDX_W        = 2;
    localparam int WORD_CYC     = DATA_W * 2 * CLK_DIV + LE_CYCLES + CLK_DIV;  // 134
    localparam int SHIFT_CYC    = NUM_WORDS * WORD_CYC;                       // 402
    localparam int QW           = DEV_W + DATA_W;

    typedef struct packed {
        logic [NUM_WORDS-1:0][DATA_W-1:0] data;
        logic [NUM_WORDS-1:0][DEV_W-1:0]  dev;
        logic                             exp_done;
        logic                             exp_err;
    } vec_t;

    logic                             clk = 1'b0;
    logic                             rst_n = 1'b0;
    logic                             start = 1'b0;
    logic                             lock_in = 1'b0;
    logic [NUM_WORDS-1:0][DATA_W-1:0] cfg_data = '0;
    logic [NUM_WORDS-1:0][DEV_W-1:0]  cfg_dev = '0;
    logic                             busy, done, error;
    logic [IDX_W-1:0]                 word_idx;
    logic                             uwire_clk, uwire_data;
    logic [NUM_DEV-1:0]               uwire_le;
    dbg_t                             dbg;

    int         total = 0;
    int         bad = 0;
    logic [QW-1:0] exp_q[$];
    vec_t       vecs[3];
    vec_t       vrst;

    uwire_cfg_engine #(
        .DATA_W       (DATA_W),
        .NUM_WORDS    (NUM_WORDS),
        .NUM_DEV      (NUM_DEV),
        .CLK_DIV      (CLK_DIV),
        .LE_CYCLES    (LE_CYCLES),
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_data   (cfg_data),
        .cfg_dev    (cfg_dev),
        .lock_in    (lock_in),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_idx   (word_idx),
        .uwire_clk  (uwire_clk),
        .uwire_data (uwire_data),
        .uwire_le   (uwire_le),
        .dbg        (dbg)
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard: rebuilds each serial word and pairs it with its LE pulse
    logic               prev_sclk = 1'b0;
    logic               prev_busy = 1'b0;
    logic [NUM_DEV-1:0] prev_le = '0;
    logic [NUM_DEV-1:0] le_val = '0;
    logic [NUM_DEV-1:0] mon_exp_le;
    logic [QW-1:0]      mon_e;
    logic [DATA_W-1:0]  cap_word = '0;
    int                 cap_bits = 0;
    int                 le_len = 0;
    int                 overlap = 0;
    int                 bitdone_cnt = 0;
    int                 busy_len = 0;
    int                 last_busy_len = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_sclk = 1'b0;
            prev_busy = 1'b0;
            prev_le   = '0;
            cap_bits  = 0;
            le_len    = 0;
            busy_len  = 0;
        end else begin
            if (busy && !prev_busy) begin
                busy_len    = 1;
                bitdone_cnt = 0;
            end else if (busy) begin
                busy_len++;
            end
            if (!busy && prev_busy) last_busy_len = busy_len;
            if (dbg.bit_done) bitdone_cnt++;
            if (uwire_clk && !prev_sclk) begin
                if (cap_bits == DATA_W) cap_bits = 0;
                cap_word = {cap_word[DATA_W-2:0], uwire_data};
                cap_bits++;
            end
            if (uwire_le != '0 && uwire_clk) overlap++;
            if (uwire_le != '0) begin
                if (prev_le == '0) begin
                    le_val = uwire_le;
                    le_len = 1;
                end else begin
                    le_len++;
                end
            end else if (prev_le != '0) begin
                if (exp_q.size() == 0) begin
                    check("le_unexpected", 64'(le_val), 64'd0);
                end else begin
                    mon_e      = exp_q.pop_front();
                    mon_exp_le = '0;
                    mon_exp_le[mon_e[QW-1:DATA_W]] = 1'b1;
                    check("le_dev", 64'(le_val), 64'(mon_exp_le));
                    check("le_word", 64'(cap_word), 64'(mon_e[DATA_W-1:0]));
                    check("le_bits", cap_bits, DATA_W);
                    check("le_len", le_len, LE_CYCLES);
                end
                cap_bits = 0;
            end
            prev_sclk = uwire_clk;
            prev_busy = busy;
            prev_le   = uwire_le;
        end
    end

    // Driver tasks
    task automatic load_table(input vec_t v);
        cfg_data = v.data;
        cfg_dev  = v.dev;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (int'(v.dev[i]) < NUM_DEV) exp_q.push_back({v.dev[i], v.data[i]});
        end
    endtask

    // Returns 1 ns after the edge that samples start.
    task automatic pulse_start();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        check(name, 64'(busy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int id);
        lock_in = 1'b1;
        load_table(v);
        pulse_start();
        check($sformatf("v%0d_busy_start", id), 64'(busy), 64'd1);
        check($sformatf("v%0d_first_bit", id), 64'(uwire_data), 64'(v.data[0][DATA_W-1]));
        check($sformatf("v%0d_clk_low", id), 64'(uwire_clk), 64'd0);
        wait_idle($sformatf("v%0d_idle", id), SHIFT_CYC + LOCK_STABLE + 50);
        check($sformatf("v%0d_done", id), 64'(done), 64'(v.exp_done));
        check($sformatf("v%0d_error", id), 64'(error), 64'(v.exp_err));
        check($sformatf("v%0d_word_idx", id), 64'(word_idx), 64'(NUM_WORDS));
        check($sformatf("v%0d_busy_len", id), last_busy_len, SHIFT_CYC + LOCK_STABLE);
        check($sformatf("v%0d_bit_done", id), bitdone_cnt, NUM_WORDS * DATA_W);
        check($sformatf("v%0d_q_empty", id), exp_q.size(), 0);
    endtask

    initial begin
        int rise_at;

        vecs[0].data[0] = 32'hA5A5_0F0F; vecs[0].dev[0] = 2'd2;
        vecs[0].data[1] = 32'h0000_0001; vecs[0].dev[1] = 2'd0;
        vecs[0].data[2] = 32'hFFFF_FFFF; vecs[0].dev[2] = 2'd1;
        vecs[0].exp_done = 1'b1;         vecs[0].exp_err = 1'b0;
        vecs[1].data[0] = 32'h8016_0140; vecs[1].dev[0] = 2'd0;
        vecs[1].data[1] = 32'h1234_5678; vecs[1].dev[1] = 2'd1;
        vecs[1].data[2] = 32'h8000_0000; vecs[1].dev[2] = 2'd2;
        vecs[1].exp_done = 1'b1;         vecs[1].exp_err = 1'b0;
        vecs[2].data[0] = 32'hDEAD_BEEF; vecs[2].dev[0] = 2'd1;
        vecs[2].data[1] = 32'h0000_0000; vecs[2].dev[1] = 2'd3;
        vecs[2].data[2] = 32'h7FFF_FFFE; vecs[2].dev[2] = 2'd0;
        vecs[2].exp_done = 1'b1;         vecs[2].exp_err = 1'b1;
        vrst.data[0] = 32'h0F0F_0F0F;    vrst.dev[0] = 2'd0;
        vrst.data[1] = 32'h1234_5678;    vrst.dev[1] = 2'd3;
        vrst.data[2] = 32'hFFFF_FFFF;    vrst.dev[2] = 2'd2;
        vrst.exp_done = 1'b0;            vrst.exp_err = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", 64'({busy, done, error, word_idx, uwire_clk, uwire_data, uwire_le}), 64'd0);
        check("reset_state", 64'(dbg.state), 64'(ST_IDLE));
        rst_n = 1'b1;

        for (int i = 0; i < 3; i++) run_vec(vecs[i], i);

        // Lock never arrives: timeout exactly LOCK_TIMEOUT cycles after lock wait entry
        lock_in = 1'b0;
        load_table(vecs[1]);
        pulse_start();
        wait_idle("tmo_idle", SHIFT_CYC + LOCK_TIMEOUT + 50);
        check("tmo_error", 64'(error), 64'd1);
        check("tmo_done", 64'(done), 64'd0);
        check("tmo_busy_len", last_busy_len, SHIFT_CYC + LOCK_TIMEOUT);
        check("tmo_q_empty", exp_q.size(), 0);

        // Lock glitch restarts stability count; done 2+LOCK_STABLE cycles after final rise
        load_table(vecs[1]);
        pulse_start();
        repeat (SHIFT_CYC + 5) @(posedge clk);
        #1 lock_in = 1'b1;
        repeat (8) @(posedge clk);
        #1 lock_in = 1'b0;
        @(posedge clk);
        #1 lock_in = 1'b1;
        rise_at = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (done && rise_at < 0) rise_at = k;
        end
        check("glitch_latency", rise_at, 2 + LOCK_STABLE);
        wait_idle("glitch_idle", 10);
        check("glitch_error", 64'(error), 64'd0);

        // Second start during shifting is ignored
        load_table(vecs[0]);
        pulse_start();
        repeat (20) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("restart_idle", SHIFT_CYC + LOCK_STABLE + 50);
        check("restart_busy_len", last_busy_len, SHIFT_CYC + LOCK_STABLE);
        check("restart_done", 64'(done), 64'd1);
        check("restart_q_empty", exp_q.size(), 0);

        // Reset during bit 10 of word 3 (sclk high, data 1), then a clean rerun
        load_table(vrst);
        pulse_start();
        repeat (2 * WORD_CYC + 9 * 2 * CLK_DIV + 2) @(posedge clk);
        #1;
        check("pre_reset", 64'({busy, error, word_idx, uwire_clk, uwire_data}), 64'({1'b1, 1'b1, 2'd2, 1'b1, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("mid_reset_outputs", 64'({busy, done, error, word_idx, uwire_clk, uwire_data, uwire_le}), 64'd0);
        check("mid_reset_state", 64'(dbg.state), 64'(ST_IDLE));
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("post_reset_le", 64'(uwire_le), 64'd0);
        run_vec(vecs[0], 3);

        check("le_clk_overlap", overlap, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
